// File: rtl/mul32_seq_ctrl.sv
// rtl/mul32_seq_ctrl.sv - 32x32 unsigned multiply sequenced over one shared 16x16 multiplier
module mul32_seq_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_vld,
  input  logic [31:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_p,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] a_q, b_q;
  logic [15:0] mul_a_q, mul_b_q;
  logic        mul_vld_q;
  logic [1:0]  tag_q;
  logic [63:0] acc_q;
  logic [63:0] out_p_q;
  logic [2:0]  ret_cnt_q;
  logic        in_ready_q, out_valid_q, busy_q;
  logic        ret_vld;
  logic [1:0]  ret_tag;
  logic [63:0] ret_term;
  logic        accept;

  // Pass k picks {A half, B half}: bit0 selects aH, bit1 selects bH.
  function automatic logic [31:0] pass_ops(input logic [1:0] k, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [15:0] opa, opb;
    opa = k[0] ? a[31:16] : a[15:0];
    opb = k[1] ? b[31:16] : b[15:0];
    return {opa, opb};
  endfunction

  assign accept = (state_q == S_IDLE) && in_valid;

  // Control FSM: captures operands, issues four passes, waits for returns, holds the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_vld_q   <= 1'b0;
      tag_q       <= '0;
      out_p_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q                <= in_a;
            b_q                <= in_b;
            {mul_a_q, mul_b_q} <= pass_ops(2'd0, in_a, in_b);
            mul_vld_q          <= 1'b1;
            tag_q              <= 2'd0;
            in_ready_q         <= 1'b0;
            busy_q             <= 1'b1;
            state_q            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tag_q == 2'd3) begin
            // Park the multiplier inputs at zero so an idle multiplier does not toggle.
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_vld_q <= 1'b0;
            state_q   <= S_DRAIN;
          end else begin
            tag_q              <= tag_q + 2'd1;
            {mul_a_q, mul_b_q} <= pass_ops(tag_q + 2'd1, a_q, b_q);
          end
        end
        S_DRAIN: begin
          // Also absorbs the final accumulate cycle, so it lasts at least one cycle.
          if (ret_cnt_q == 3'd4) begin
            out_p_q     <= acc_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  generate
    if (MUL_LAT == 0) begin : g_tag_comb
      assign ret_vld = mul_vld_q;
      assign ret_tag = tag_q;
    end else begin : g_tag_pipe
      logic [MUL_LAT-1:0] vld_pipe_q;
      logic [1:0]         tag_pipe_q [MUL_LAT];

      // Valid + pass tag follow each issue through the multiplier's latency.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe_q <= '0;
          for (int i = 0; i < MUL_LAT; i++) tag_pipe_q[i] <= '0;
        end else begin
          vld_pipe_q[0] <= mul_vld_q;
          tag_pipe_q[0] <= tag_q;
          for (int i = 1; i < MUL_LAT; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            tag_pipe_q[i] <= tag_pipe_q[i-1];
          end
        end
      end

      assign ret_vld = vld_pipe_q[MUL_LAT-1];
      assign ret_tag = tag_pipe_q[MUL_LAT-1];
    end
  endgenerate

  // Weight the returning partial product by its pass position.
  always_comb begin
    ret_term = '0;
    case (ret_tag)
      2'd0:    ret_term = {32'd0, mul_p};
      2'd1,
      2'd2:    ret_term = {16'd0, mul_p, 16'd0};
      default: ret_term = {mul_p, 32'd0};
    endcase
  end

  // Accumulate tagged returns; cleared on each accepted operand pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      ret_cnt_q <= '0;
    end else if (accept) begin
      acc_q     <= '0;
      ret_cnt_q <= '0;
    end else if (ret_vld) begin
      acc_q     <= acc_q + ret_term;
      ret_cnt_q <= ret_cnt_q + 3'd1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_vld   = mul_vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb/tb_mul32_seq_ctrl.sv - scoreboard bench for mul32_seq_ctrl at MUL_LAT 1, 0 and 3
module tb_mul32_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] in_a      [3];
  logic [31:0] in_b      [3];
  logic [15:0] mul_a     [3];
  logic [15:0] mul_b     [3];
  logic        mul_vld   [3];
  logic [31:0] mul_p     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [63:0] out_p     [3];
  logic        busy      [3];

  // Lane 0: MUL_LAT=1, lane 1: MUL_LAT=0, lane 2: MUL_LAT=3
  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : ((l == 1) ? 0 : 3);
  endfunction

  generate
    for (genvar i = 0; i < 3; i++) begin : g_lane
      localparam int LAT = (i == 0) ? 1 : ((i == 1) ? 0 : 3);

      mul32_seq_ctrl #(.MUL_LAT(LAT)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid[i]),
        .in_ready (in_ready[i]),
        .in_a     (in_a[i]),
        .in_b     (in_b[i]),
        .mul_a    (mul_a[i]),
        .mul_b    (mul_b[i]),
        .mul_vld  (mul_vld[i]),
        .mul_p    (mul_p[i]),
        .out_valid(out_valid[i]),
        .out_ready(out_ready[i]),
        .out_p    (out_p[i]),
        .busy     (busy[i])
      );

      if (LAT == 0) begin : g_mul_c
        assign mul_p[i] = 32'(mul_a[i]) * 32'(mul_b[i]);
      end else begin : g_mul_r
        logic [31:0] pipe_q [LAT];
        always @(posedge clk) begin
          pipe_q[0] <= 32'(mul_a[i]) * 32'(mul_b[i]);
          for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
        assign mul_p[i] = pipe_q[LAT-1];
      end
    end
  endgenerate

  typedef struct {
    int          lane;
    logic [63:0] p;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_v [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency on out_valid rise, value on each out handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      if (out_valid[l] && !prev_v[l]) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: lane %0d got out_valid=1 expected none", l);
        end else begin
          chk("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
          chk("lane", 64'(l), 64'(q[0].lane));
        end
      end
      if (out_valid[l] && out_ready[l] && q.size() != 0) begin
        e = q.pop_front();
        chk("out_p", out_p[l], e.p);
      end
      prev_v[l] = out_valid[l];
    end
  end

  // Present one operand pair, push the expectation at acceptance, optionally check pass order.
  task automatic op(input int l, input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] p, input bit chk_pass, input bit keep_valid,
                    output int acc_at);
    int          n;
    exp_t        e;
    logic [15:0] ea, eb;
    in_a[l]     = a;
    in_b[l]     = b;
    in_valid[l] = 1'b1;
    n = 0;
    while (!in_ready[l] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[l]) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: lane %0d in_ready=0 expected 1", l);
      in_valid[l] = 1'b0;
      acc_at = -1;
      return;
    end
    e.lane    = l;
    e.p       = p;
    e.lat     = lat_of(l) + 5;
    e.acc_cyc = cyc + 1;
    acc_at    = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    if (!keep_valid) in_valid[l] = 1'b0;
    if (chk_pass) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        case (k)
          0:       begin ea = a[15:0];  eb = b[15:0];  end
          1:       begin ea = a[31:16]; eb = b[15:0];  end
          2:       begin ea = a[15:0];  eb = b[31:16]; end
          default: begin ea = a[31:16]; eb = b[31:16]; end
        endcase
        chk("pass_vld", 64'(mul_vld[l]), 64'd1);
        chk("pass_a", 64'(mul_a[l]), 64'(ea));
        chk("pass_b", 64'(mul_b[l]), 64'(eb));
      end
      @(negedge clk);
      chk("idle_vld", 64'(mul_vld[l]), 64'd0);
      chk("idle_a", 64'(mul_a[l]), 64'd0);
      chk("idle_b", 64'(mul_b[l]), 64'd0);
    end
  endtask

  task automatic wait_idle(input int l);
    int n;
    n = 0;
    while ((busy[l] || q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy[l] || q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: lane %0d busy=%0d pending=%0d expected 0", l, busy[l], q.size());
    end
  endtask

  initial begin
    int t0, t1, t2, n;
    rst_n = 1'b0;
    for (int l = 0; l < 3; l++) begin
      in_valid[l]  = 1'b0;
      in_a[l]      = '0;
      in_b[l]      = '0;
      out_ready[l] = 1'b1;
    end
    repeat (2) @(negedge clk);

    chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_out_p", out_p[0], 64'd0);
    chk("rst_mul_vld", 64'(mul_vld[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single cross term at <<32
    op(0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1, 1'b0, t0);
    wait_idle(0);

    // All ones, with pass-order checks
    op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, t0);
    wait_idle(0);

    // Back-pressure: result and in_ready hold while in_a/in_b churn
    out_ready[0] = 1'b0;
    op(0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 1'b1, 1'b0, t0);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      in_a[0]     = 32'hDEAD_0000 + 32'(i);
      in_b[0]     = 32'h0000_BEEF + 32'(i);
      chk("hold_out_p", out_p[0], 64'h0B00_EA4E_242D_2080);
      chk("hold_out_valid", 64'(out_valid[0]), 64'd1);
      chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
      @(negedge clk);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    wait_idle(0);
    repeat (4) @(negedge clk);
    chk("hold_single_handshake_busy", 64'(busy[0]), 64'd0);

    // in_valid held high across three back-to-back operations
    op(0, 32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006, 1'b1, 1'b1, t0);
    op(0, 32'h0001_0001, 32'h0001_0001, 64'h0000_0001_0002_0001, 1'b1, 1'b1, t1);
    op(0, 32'hFFFF_0000, 32'h0000_FFFF, 64'h0000_FFFE_0001_0000, 1'b1, 1'b0, t2);
    chk("spacing_1", 64'(t1 - t0), 64'(lat_of(0) + 7));
    chk("spacing_2", 64'(t2 - t1), 64'(lat_of(0) + 7));
    wait_idle(0);

    // Reset during pass 2 discards the operation
    op(0, 32'hAAAA_5555, 32'h1234_FFFF, 64'h0, 1'b0, 1'b0, t0);
    @(negedge clk);
    @(negedge clk);
    chk("pass2_live_a", 64'(mul_a[0]), 64'h5555);
    chk("pass2_live_b", 64'(mul_b[0]), 64'h1234);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_out_p", out_p[0], 64'd0);
    chk("mid_rst_mul_a", 64'(mul_a[0]), 64'd0);
    chk("mid_rst_mul_b", 64'(mul_b[0]), 64'd0);
    chk("mid_rst_mul_vld", 64'(mul_vld[0]), 64'd0);
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    q.delete(q.size() - 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("post_rst_busy", 64'(busy[0]), 64'd0);
    op(0, 32'd3, 32'd5, 64'd15, 1'b1, 1'b0, t0);
    wait_idle(0);

    // Same all-ones vector at MUL_LAT=0 and MUL_LAT=3
    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, t0);
    wait_idle(1);
    op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, t0);
    wait_idle(2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
